// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: FSM state encoding and bit positions of the I2C address/R-W byte shared by the I2C register-file slave
package i2c_slave_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;
    localparam int RW_BIT   = 0;
    localparam int ADDR_LSB = 1;
    localparam int ADDR_MSB = 7;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-flop synchronisers for scl/sda_i with SCL edge and START/STOP detection; in clk, rst, scl, sda_i; out sda (synchronised), scl_rise, scl_fall, start, stop
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [1:0] scl_m, sda_m;
    logic scl_d, sda_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_m <= 2'b11;
            sda_m <= 2'b11;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_m <= {scl_m[0], scl};
            sda_m <= {sda_m[0], sda_i};
            scl_d <= scl_m[1];
            sda_d <= sda_m[1];
        end
    end
    assign sda      = sda_m[1];
    assign scl_rise = scl_m[1] & ~scl_d;
    assign scl_fall = ~scl_m[1] & scl_d;
    assign start    = scl_m[1] & scl_d & sda_d & ~sda_m[1];
    assign stop     = scl_m[1] & scl_d & ~sda_d & sda_m[1];
endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave exposing DEPTH 8-bit registers (ptr byte then data bytes); ports clk, rst, scl, sda_i, sda_oe, out, wr_pulse, host_addr, host_data; define I2C_SLAVE_AUTOINC_EN to auto-increment ptr after each ACKed data byte
module i2c_slave_regfile
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h69,
    parameter int         DEPTH      = 32,
    parameter int         AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic [7:0]    out,
    output logic          wr_pulse,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_data
);
    state_t state, nxt;
    logic sda, scl_rise, scl_fall, start, stop;
    logic [7:0] sh, sh_in;
    logic [3:0] cnt;
    logic [AW-1:0] ptr, ptr_step;
    logic mack, addr_hit, ptr_ok;
    logic [7:0] regs [DEPTH];

    i2c_bus_sync u_sync (
        .clk(clk), .rst(rst), .scl(scl), .sda_i(sda_i),
        .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
    );

    assign sh_in     = {sh[6:0], sda};
    assign addr_hit  = sh[ADDR_MSB:ADDR_LSB] == SLAVE_ADDR;
    assign ptr_ok    = {24'd0, sh} < 32'(DEPTH);
    assign host_data = regs[host_addr];
`ifdef I2C_SLAVE_AUTOINC_EN
    assign ptr_step = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
`else
    assign ptr_step = ptr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (start) nxt = ADDR;
        else if (stop) nxt = IDLE;
        else if (scl_fall) begin
            case (state)
                ADDR:      nxt = (cnt != 4'd8) ? ADDR : addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:  nxt = sh[RW_BIT] ? RDATA : PTR;
                PTR:       nxt = (cnt != 4'd8) ? PTR : ptr_ok ? PTR_ACK : WAIT_STOP;
                PTR_ACK:   nxt = WDATA;
                WDATA:     nxt = (cnt == 4'd8) ? WDATA_ACK : WDATA;
                WDATA_ACK: nxt = WDATA;
                RDATA:     nxt = (cnt == 4'd7) ? RDATA_ACK : RDATA;
                RDATA_ACK: nxt = mack ? WAIT_STOP : RDATA;
                default:   nxt = state;
            endcase
        end
    end

    always_comb begin
        sda_oe = (state == ADDR_ACK || state == PTR_ACK || state == WDATA_ACK) ? 1'b1 :
                 (state == RDATA) ? ~sh[7] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh       <= '0;
            cnt      <= '0;
            ptr      <= '0;
            mack     <= 1'b1;
            out      <= '0;
            wr_pulse <= 1'b0;
            regs     <= '{default: 8'h00};
        end else begin
            wr_pulse <= 1'b0;
            if (start) cnt <= '0;
            else if (!stop) begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            sh  <= sh_in;
                            cnt <= cnt + 1'b1;
                            if (state == WDATA && cnt == 4'd7) begin
                                regs[ptr] <= sh_in;
                                out       <= sh_in;
                                wr_pulse  <= 1'b1;
                            end
                        end
                        if (scl_fall && state == PTR && cnt == 4'd8 && ptr_ok) ptr <= sh[AW-1:0];
                    end
                    ADDR_ACK: if (scl_fall) begin
                        cnt <= '0;
                        if (sh[RW_BIT]) begin
                            sh  <= regs[ptr];
                            out <= regs[ptr];
                        end
                    end
                    PTR_ACK: if (scl_fall) cnt <= '0;
                    WDATA_ACK: if (scl_fall) begin
                        cnt <= '0;
                        ptr <= ptr_step;
                    end
                    RDATA: if (scl_fall) begin
                        sh  <= {sh[6:0], 1'b0};
                        cnt <= cnt + 1'b1;
                    end
                    RDATA_ACK: begin
                        if (scl_rise) mack <= sda;
                        if (scl_fall) begin
                            cnt <= '0;
                            if (!mack) begin
                                ptr <= ptr_step;
                                sh  <= regs[ptr_step];
                                out <= regs[ptr_step];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
